// File: rtl/mux_sel_arb2.sv
// ---------------------------------------------------------------------------
// mux_sel_arb2
//
// Two-source round-robin arbiter with a valid/ready handshake and a single
// registered output stage. It drives the select for the downstream 2:1 mux
// and registers the chosen beat, so one consumer is shared fairly between
// source A and source B.
//
// Optional feature macro: ARB_LOCK_EN
//   defined   - packet lock. Once a source transfers a beat with last=0 it
//               owns the output until it transfers a beat with last=1.
//               FSM states: ARB, LOCK_A, LOCK_B.
//   undefined - every beat is arbitrated independently; a_last and b_last
//               are ignored.
//
// Parameters
//   WIDTH      data width of a_data, b_data and out_data (default 8)
//
// Ports
//   clk        rising-edge clock, the only clock
//   rst        synchronous reset, active-high
//   a_valid    source A offers a beat
//   a_data     source A beat
//   a_last     A beat ends a packet (lock build only)
//   a_ready    A beat is accepted this cycle
//   b_valid    source B offers a beat
//   b_data     source B beat
//   b_last     B beat ends a packet (lock build only)
//   b_ready    B beat is accepted this cycle
//   out_valid  out_data holds a valid beat
//   out_data   registered selected beat
//   out_ready  consumer accepts out_data
//   sel        source of the current out_data: 0 = A, 1 = B
// ---------------------------------------------------------------------------
module mux_sel_arb2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    input  logic [WIDTH-1:0] a_data,
    input  logic             a_last,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic [WIDTH-1:0] b_data,
    input  logic             b_last,
    output logic             b_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             sel
);

    // Output stage and round-robin history
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic             sel_q,       sel_d;
    logic             last_grant_q, last_grant_d;

    // Combinational arbitration signals
    logic load;
    logic grant;
    logic xfer;

`ifdef ARB_LOCK_EN
    typedef enum logic [1:0] {
        ARB    = 2'd0,
        LOCK_A = 2'd1,
        LOCK_B = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   grant_last;
`else
    // The last flags have no function without packet lock; this sink only
    // keeps them from showing up as dangling inputs.
    logic unused_last;
    assign unused_last = a_last ^ b_last;
`endif

    // The output register can accept a new beat when it is empty or when
    // the held beat drains on this same edge.
    assign load = ~out_valid_q | out_ready;

    // Grant: a lone requester wins; on a tie the source that did not win
    // last time wins. With neither valid the value is irrelevant because
    // both readies are gated by valid.
    always_comb begin
        grant = ~last_grant_q;
        if (a_valid && !b_valid) begin
            grant = 1'b0;
        end else if (!a_valid && b_valid) begin
            grant = 1'b1;
        end
`ifdef ARB_LOCK_EN
        // A locked owner keeps the grant even while it idles, so the other
        // source cannot slip a beat into the middle of a packet.
        if (state_q == LOCK_A) begin
            grant = 1'b0;
        end else if (state_q == LOCK_B) begin
            grant = 1'b1;
        end
`endif
    end

    // Readies depend only on the grant, the source's own valid and the
    // downstream load condition; never on out_valid of the same source.
    assign a_ready = load & a_valid & ~grant;
    assign b_ready = load & b_valid &  grant;
    assign xfer    = a_ready | b_ready;

    // Output stage next state
    always_comb begin
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        sel_d        = sel_q;
        last_grant_d = last_grant_q;
        if (xfer) begin
            out_valid_d  = 1'b1;
            out_data_d   = grant ? b_data : a_data;
            sel_d        = grant;
            last_grant_d = grant;
        end else if (load) begin
            // Slot drains (or was empty) and nothing replaces it; data and
            // sel keep their last values.
            out_valid_d = 1'b0;
        end
    end

`ifdef ARB_LOCK_EN
    assign grant_last = grant ? b_last : a_last;

    // Packet lock FSM: a non-final beat locks onto its source, a final beat
    // releases back to round-robin. A single-beat packet never leaves ARB.
    always_comb begin
        state_d = state_q;
        if (xfer) begin
            if (grant_last) begin
                state_d = ARB;
            end else if (grant) begin
                state_d = LOCK_B;
            end else begin
                state_d = LOCK_A;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB;
        end else begin
            state_q <= state_d;
        end
    end
`endif

    // last_grant resets to B so that A wins the first tie after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            sel_q        <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            sel_q        <= sel_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign sel       = sel_q;

endmodule
